// File: rtl/data_buffer_pkg.sv
// Shared constants and helpers for the data_buffer shift-register FIFO.
package data_buffer_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 1;

    // Fill counter must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/data_buffer_stage.sv
// One storage stage of data_buffer: a DATA_W register that loads d when en is high.
module data_buffer_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/data_buffer.sv
// DEPTH-stage shift-register buffer with a saturating fill counter and o_valid pulse.
// Optional o_full status output is enabled with the DATA_BUFFER_STATUS_EN macro.
module data_buffer
    import data_buffer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    input  logic              clear,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
`ifdef DATA_BUFFER_STATUS_EN
    ,
    output logic              o_full
`endif
);

    if (DEPTH < 1) begin : g_depth_chk
        $fatal(1, "data_buffer: DEPTH must be at least 1");
    end
    if (DATA_W < 1) begin : g_width_chk
        $fatal(1, "data_buffer: DATA_W must be at least 1");
    end

    localparam int               CNT_W   = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic              shift_en;
    logic [DATA_W-1:0] stage_q [DEPTH];

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              o_valid_q;
    logic              o_valid_d;

    // clear takes priority over an incoming word: no shift, word dropped.
    assign shift_en = i_valid & ~clear;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            data_buffer_stage #(.DATA_W(DATA_W)) u_stage (
                .clk (clk),
                .rst (rst),
                .en  (shift_en),
                .d   (i_data),
                .q   (stage_q[k])
            );
        end else begin : g_body
            data_buffer_stage #(.DATA_W(DATA_W)) u_stage (
                .clk (clk),
                .rst (rst),
                .en  (shift_en),
                .d   (stage_q[k-1]),
                .q   (stage_q[k])
            );
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        o_valid_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (i_valid) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            o_valid_d = (cnt_d == CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            o_valid_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign o_data  = stage_q[DEPTH-1];
    assign o_valid = o_valid_q;

`ifdef DATA_BUFFER_STATUS_EN
    logic full_q;
    logic full_d;

    // Tracks the counter value being loaded so o_full matches counter==DEPTH.
    always_comb begin
        full_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    assign o_full = full_q;
`endif

endmodule

// File: tb/tb_data_buffer.sv
// Scoreboard bench for data_buffer: DEPTH=1, 2 and 4 instances share one stimulus stream.
module tb_data_buffer;

    localparam int NDUT = 3;
    localparam int DEP [NDUT] = '{1, 2, 4};

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] i_data;
    logic        i_valid;
    logic        clear;
    logic [31:0] od [NDUT];
    logic        ov [NDUT];
`ifdef DATA_BUFFER_STATUS_EN
    logic        full_w [NDUT];
`endif

    int          cyc;
    int          checks;
    int          errors;
    int          pulses1;
    bit          mon_en;
    logic [31:0] hist [NDUT][$];
    exp_t        expq [NDUT][$];

    data_buffer #(.DATA_W(32), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .clear(clear),
        .o_data(od[0]), .o_valid(ov[0])
`ifdef DATA_BUFFER_STATUS_EN
        , .o_full(full_w[0])
`endif
    );

    data_buffer #(.DATA_W(32), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .clear(clear),
        .o_data(od[1]), .o_valid(ov[1])
`ifdef DATA_BUFFER_STATUS_EN
        , .o_full(full_w[1])
`endif
    );

    data_buffer #(.DATA_W(32), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .clear(clear),
        .o_data(od[2]), .o_valid(ov[2])
`ifdef DATA_BUFFER_STATUS_EN
        , .o_full(full_w[2])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int dut, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s depth=%0d cyc=%0d: got %h expected %h", name, DEP[dut], cyc, got, want);
        end
    endtask

    // Reference model: word n leaves when word n+DEPTH-1 is accepted, one clock later.
    task automatic step(input logic v, input logic [31:0] d, input logic c);
        i_valid = v;
        i_data  = d;
        clear   = c;
        for (int k = 0; k < NDUT; k++) begin
            if (c) begin
                hist[k].delete();
            end else if (v) begin
                hist[k].push_back(d);
                if (hist[k].size() >= DEP[k]) begin
                    expq[k].push_back('{cyc + 1, hist[k][hist[k].size() - DEP[k]]});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic purge();
        for (int k = 0; k < NDUT; k++) begin
            hist[k].delete();
            expq[k].delete();
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < NDUT; k++) begin
                if (expq[k].size() > 0 && expq[k][0].due == cyc) begin
                    chk("o_valid_pulse", k, {31'b0, ov[k]}, 32'd1);
                    chk("o_data_order", k, od[k], expq[k][0].data);
                    void'(expq[k].pop_front());
                end else begin
                    chk("o_valid_idle", k, {31'b0, ov[k]}, 32'd0);
                end
            end
            if (ov[0]) pulses1++;
        end
    end

    initial begin
        logic [31:0] w;
        cyc     = 0;
        checks  = 0;
        errors  = 0;
        pulses1 = 0;
        mon_en  = 1'b0;
        rst     = 1'b0;
        i_data  = '0;
        i_valid = 1'b0;
        clear   = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("reset_o_valid", k, {31'b0, ov[k]}, 32'd0);
            chk("reset_o_data", k, od[k], 32'd0);
        end
        rst    = 1'b1;
        mon_en = 1'b1;

        // 100 random words with i_valid alternating.
        pulses1 = 0;
        for (int n = 0; n < 100; n++) begin
            step(1'b0, $urandom, 1'b0);
            step(1'b1, $urandom, 1'b0);
        end
        step(1'b0, 32'd0, 1'b0);
        @(negedge clk);
        chk("depth1_pulse_count", 0, pulses1, 32'd100);

        // Back-to-back 1..5 into a freshly cleared buffer.
        step(1'b0, 32'd0, 1'b1);
        for (int n = 1; n <= 5; n++) begin
            step(1'b1, n, 1'b0);
            @(negedge clk);
            if (n == 4) chk("d4_first_word", 2, od[2], 32'h1);
            if (n == 5) chk("d4_second_word", 2, od[2], 32'h2);
            chk("d4_valid_after_word", 2, {31'b0, ov[2]}, (n >= 4) ? 32'd1 : 32'd0);
        end

        // 3 words, clear, then 0xA..0xD: first delivery must be 0xA.
        for (int n = 0; n < 3; n++) step(1'b1, 32'h70 + n, 1'b0);
        step(1'b0, 32'd0, 1'b1);
        for (int n = 0; n < 4; n++) begin
            step(1'b1, 32'hA + n, 1'b0);
            @(negedge clk);
            chk("post_clear_valid", 2, {31'b0, ov[2]}, (n == 3) ? 32'd1 : 32'd0);
        end
        chk("post_clear_first", 2, od[2], 32'hA);

        // Clear with a word present: word dropped, stage0 untouched.
        step(1'b1, 32'h55, 1'b0);
        step(1'b1, 32'hFF, 1'b1);
        @(negedge clk);
        chk("clear_drop_stage0", 0, od[0], 32'h55);
        chk("clear_drop_valid", 0, {31'b0, ov[0]}, 32'd0);

`ifdef DATA_BUFFER_STATUS_EN
        step(1'b1, 32'h11, 1'b0);
        chk("full_one_word", 1, {31'b0, full_w[1]}, 32'd0);
        step(1'b1, 32'h12, 1'b0);
        chk("full_two_words", 1, {31'b0, full_w[1]}, 32'd1);
        step(1'b1, 32'h13, 1'b0);
        chk("full_saturated", 1, {31'b0, full_w[1]}, 32'd1);
        step(1'b0, 32'h0, 1'b1);
        chk("full_after_clear", 1, {31'b0, full_w[1]}, 32'd0);
`endif

        // Random gapped traffic with occasional clears.
        for (int n = 0; n < 300; n++) begin
            w = $urandom;
            step(($urandom_range(0, 2) != 0), w, ($urandom_range(0, 15) == 0));
        end

        // Mid-stream asynchronous reset.
        for (int n = 0; n < 5; n++) step(1'b1, $urandom, 1'b0);
        #2;
        rst = 1'b0;
        purge();
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("async_rst_o_valid", k, {31'b0, ov[k]}, 32'd0);
            chk("async_rst_o_data", k, od[k], 32'd0);
        end
        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        rst = 1'b1;
        for (int n = 0; n < 40; n++) step(($urandom_range(0, 3) != 0), $urandom, 1'b0);

        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        @(negedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("scoreboard_drained", k, expq[k].size(), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
